fetch_buffer: RTL and testbench

- Instruction queue between the fetch stage and the decode stage.
- Accepts {pc, inst} pairs from fetch over a valid/ready handshake and presents them in order to decode on its pc/inst inputs.
- Decouples fetch from back-end stalls caused by rename, ROB or RS full conditions.
- Flushed on branch/jump redirect from the branch unit.

---
 rtl/fetch_buffer.sv | 70 +++++++
 tb/tb_fetch_buffer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order {pc, inst} queue between fetch and decode, flushed on redirect.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  redirect flush, discards all entries
//   enq_valid_i/enq_ready_o  fetch handshake carrying enq_pc_i/enq_inst_i
//   deq_valid_o/deq_ready_i  decode handshake carrying deq_pc_o/deq_inst_o (NOP when invalid)
//   count_o                  registered occupancy, 0..DEPTH
// Optional: define FETCH_BUF_BYPASS_EN for a zero-latency enq-to-deq path when empty.
module fetch_buffer #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [31:0]      enq_pc_i,
  input  logic [31:0]      enq_inst_i,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [31:0]      deq_pc_o,
  output logic [31:0]      deq_inst_o,
  output logic [PTR_W:0]   count_o
);
  logic [63:0]    mem_q [DEPTH];
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;
  logic           empty, full, bypass, enq_fire, deq_fire;
  logic [63:0]    head;

  assign empty = rd_ptr_q == wr_ptr_q;
  assign full  = (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]) && (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]);
  assign enq_ready_o = !full && !flush_i;
`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = empty && !flush_i && enq_valid_i;
`else
  assign bypass = 1'b0;
`endif
  assign deq_valid_o = (!empty && !flush_i) || bypass;
  // a bypassed instruction consumed in the same cycle is never written
  assign enq_fire = enq_valid_i && enq_ready_o && !(bypass && deq_ready_i);
  // bypass implies empty, so storage is only popped when it holds the head
  assign deq_fire = deq_valid_o && deq_ready_i && !bypass;
  assign head = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign deq_pc_o   = !deq_valid_o ? 32'h0        : bypass ? enq_pc_i   : head[63:32];
  assign deq_inst_o = !deq_valid_o ? 32'h00000013 : bypass ? enq_inst_i : head[31:0];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + (PTR_W+1)'(deq_fire);
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + (PTR_W+1)'(enq_fire);
    count_d  = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_fire) mem_q[wr_ptr_q[PTR_W-1:0]] <= {enq_pc_i, enq_inst_i};
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
  localparam int DEPTH = 8;
`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, enq_v = 1'b0, deq_r = 1'b0;
  logic        enq_rdy, deq_vld;
  logic [31:0] pc = 32'h0, inst = 32'h0, deq_pc, deq_inst;
  logic [3:0]  count;
  int          checks = 0, errors = 0;
  int          occ = 0;
  logic [63:0] sb [$];
  bit          m_acc = 1'b0, m_valid = 1'b0, fresh = 1'b1;
  bit          e_rdy, e_vld;
  int          e_cnt;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .enq_valid_i(enq_v), .enq_ready_o(enq_rdy), .enq_pc_i(pc), .enq_inst_i(inst),
    .deq_valid_o(deq_vld), .deq_ready_i(deq_r), .deq_pc_o(deq_pc), .deq_inst_o(deq_inst),
    .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: occupancy plus an ordered queue of accepted {pc, inst}
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
      sb.delete();
      m_acc = 1'b0;
      m_valid = 1'b0;
    end else begin
      e_cnt = occ;
      e_rdy = !flush && occ < DEPTH;
      e_vld = !flush && (occ > 0 || (BYP && enq_v));
      m_acc = e_rdy && enq_v;
      if (m_acc) sb.push_back({pc, inst});
      if (flush) begin
        occ = 0;
        sb.delete();
      end else occ = occ + int'(m_acc) - int'(e_vld && deq_r);
      m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    #1;
    if (m_valid && rst_n) begin
      chk("enq_ready", 32'(enq_rdy), 32'(e_rdy));
      chk("deq_valid", 32'(deq_vld), 32'(e_vld));
      chk("count", 32'(count), 32'(e_cnt));
      if (deq_vld) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_underflow: got valid head expected empty at %0t", $time);
        end else begin
          chk("deq_pc", deq_pc, sb[0][63:32]);
          chk("deq_inst", deq_inst, sb[0][31:0]);
          if (deq_r) void'(sb.pop_front());
        end
      end else begin
        chk("nop_pc", deq_pc, 32'h0);
        chk("nop_inst", deq_inst, 32'h00000013);
      end
    end
  end

  task automatic set_pc(input logic [31:0] p);
    pc = p;
    inst = 32'h00100093 + (p >> 2);
    fresh = 1'b1;
  endtask

  // the source holds its data until the model says it was accepted
  task automatic step(input bit ev, input bit dr, input bit fl);
    @(posedge clk);
    #1;
    if (m_acc && !fresh) begin
      pc = pc + 32'h4;
      inst = 32'h00100093 + (pc >> 2);
    end
    fresh = 1'b0;
    enq_v = ev;
    deq_r = dr;
    flush = fl;
  endtask

  initial begin
    #12;
    chk("rst_deq_valid", 32'(deq_vld), 32'h0);
    chk("rst_deq_pc", deq_pc, 32'h0);
    chk("rst_deq_inst", deq_inst, 32'h00000013);
    chk("rst_count", 32'(count), 32'h0);
    #1 rst_n = 1'b1;
    #1 chk("rst_enq_ready", 32'(enq_rdy), 32'h1);
    set_pc(32'h0);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    set_pc(32'h100);
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    set_pc(32'h180);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(1, 0, 1);
    step(0, 0, 0);
    set_pc(32'h200);
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    set_pc(32'h300);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    enq_v = 1'b0;
    #1;
    chk("async_rst_deq_valid", 32'(deq_vld), 32'h0);
    chk("async_rst_count", 32'(count), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    set_pc(32'h400);
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    set_pc(32'h80);
    step(1, 1, 0);
    step(0, 1, 0);
    set_pc(32'h1000);
    for (int b = 0; b < 10; b++) begin
      int eb = $urandom_range(1, 3);
      int db = $urandom_range(1, 3);
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 3) < eb, $urandom_range(0, 3) < db, $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
